// File: rtl/isp_pkg.sv
// Shared definitions for the DVP capture path: FSM encoding, FIFO geometry
// and the word/address widths used by the packer and its write FIFO.
package isp_pkg;

    localparam int WORD_W     = 64;
    localparam int ADDR_W     = 24;
    localparam int PIX_W      = 16;
    localparam int LANES      = WORD_W / PIX_W;
    localparam int FIFO_DEPTH = 4;
    localparam int ENTRY_W    = ADDR_W + WORD_W;
    localparam int PIX_CNT_W  = 20;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/sync_fifo_4x88.sv
// Four-entry {addr,data} write FIFO. A push while full is accepted only when
// a pop happens in the same cycle; otherwise the incoming entry is dropped.
module sync_fifo_4x88
    import isp_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               wr_en;
    logic               rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);

    // Head is forced to zero when empty so the outputs read 0 out of reset.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dvp_frame_packer.sv
// Packs RGB565 DVP pixels four-per-word into a ping-pong frame buffer pair,
// reporting completed frames and flagging short/long or overflowed frames.
module dvp_frame_packer
    import isp_pkg::*;
#(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [23:0] BASE_ADDR0 = 24'h000000,
    parameter logic [23:0] BASE_ADDR1 = 24'h040000
) (
    input  logic        PCLK,
    input  logic        Rst_n,
    input  logic        DataValid,
    input  logic [15:0] DataPixel,
    input  logic        DataHs,
    input  logic        DataVs,
    input  logic        WrReady,
    output logic        WrReq,
    output logic [63:0] WrData,
    output logic [23:0] WrAddr,
    output logic        FrameDone,
    output logic        FrameErr,
    output logic        ReadBuf,
    output logic        Overflow
);

    localparam logic [PIX_CNT_W-1:0] FRAME_PIX = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);

    logic [1:0]           state_q, state_d;
    logic [1:0]           pack_idx_q, pack_idx_d;
    logic [WORD_W-1:0]    acc_q, acc_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 overflow_q, overflow_d;
    logic                 read_buf_q, read_buf_d;
    logic                 vs_q, hs_q;

    logic                 vs_rise, vs_fall, hs_fall;
    logic                 in_active, take, flush, push, pop, drop;
    logic [2:0]           fill;
    logic [WORD_W-1:0]    merged;
    logic                 frame_good;
    logic                 fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_head;

    assign vs_rise   = DataVs & ~vs_q;
    assign vs_fall   = ~DataVs & vs_q;
    assign hs_fall   = ~DataHs & hs_q;
    assign in_active = (state_q == ST_ACTIVE);
    assign take      = in_active & DataValid;
    assign fill      = {1'b0, pack_idx_q} + {2'b00, take};
    assign flush     = hs_fall | vs_fall;

    // A word leaves the accumulator when the fourth lane fills, or when a line
    // or frame ends with a partly filled word (this cycle's pixel included).
    assign push = in_active & ((fill == 3'd4) | (flush & (fill != 3'd0)));
    assign pop  = ~fifo_empty & WrReady;
    assign drop = push & fifo_full & ~pop;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign merged[gi*PIX_W +: PIX_W] =
            (take && (pack_idx_q == 2'(gi))) ? DataPixel : acc_q[gi*PIX_W +: PIX_W];
    end

    assign frame_good = (pix_cnt_q == FRAME_PIX) && !overflow_q;

    sync_fifo_4x88 u_fifo (
        .clk_i       (PCLK),
        .rst_n_i     (Rst_n),
        .push_i      (push),
        .push_data_i ({addr_q, merged}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign WrReq     = ~fifo_empty;
    assign WrAddr    = fifo_head[ENTRY_W-1 -: ADDR_W];
    assign WrData    = fifo_head[WORD_W-1:0];
    assign FrameDone = (state_q == ST_DONE) & frame_good;
    assign FrameErr  = (state_q == ST_DONE) & ~frame_good;
    assign ReadBuf   = read_buf_q;
    assign Overflow  = overflow_q;

    always_comb begin
        state_d    = state_q;
        pack_idx_d = pack_idx_q;
        acc_d      = acc_q;
        pix_cnt_d  = pix_cnt_q;
        addr_d     = addr_q;
        overflow_d = overflow_q;
        read_buf_d = read_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    state_d    = ST_ACTIVE;
                    pack_idx_d = '0;
                    acc_d      = '0;
                    pix_cnt_d  = '0;
                    overflow_d = 1'b0;
                    addr_d     = read_buf_q ? BASE_ADDR0 : BASE_ADDR1;
                end
            end
            ST_ACTIVE: begin
                if (take) pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                acc_d      = merged;
                pack_idx_d = fill[1:0];
                if (push) begin
                    acc_d      = '0;
                    pack_idx_d = '0;
                    addr_d     = addr_q + ADDR_W'(1);
                    if (drop) overflow_d = 1'b1;
                end
                if (vs_fall) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (frame_good) read_buf_d = ~read_buf_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // vs_q resets high so a DataVs already high at release is not a new frame.
    always_ff @(posedge PCLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            pack_idx_q <= '0;
            acc_q      <= '0;
            pix_cnt_q  <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
            read_buf_q <= 1'b0;
            vs_q       <= 1'b1;
            hs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pack_idx_q <= pack_idx_d;
            acc_q      <= acc_d;
            pix_cnt_q  <= pix_cnt_d;
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
            read_buf_q <= read_buf_d;
            vs_q       <= DataVs;
            hs_q       <= DataHs;
        end
    end

endmodule
